// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit path.
// Contents: transmitter state encoding, default word-width constants and channel codes.
package i2s_pkg;

    localparam int unsigned I2S_DATA_W  = 32;
    localparam int unsigned I2S_MIN_LEN = 5;

    // WS level for each channel
    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } tx_state_e;

endpackage

// File: rtl/i2s_tx_serializer.sv
// Shift register plus bit down-counter for the I2S transmitter.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   load_i       load a new word (left-aligned to the MSB) and its length
//   shift_i      shift one bit out (ignored while the counter is zero)
//   data_i       word, right-aligned
//   len_i        word length in bits; only legal lengths are ever loaded
//   load_msb_o   MSB of the word currently presented on data_i/len_i
//   msb_o        current MSB of the shift register
//   next_msb_o   bit that becomes the MSB after the next shift
//   last_o       counter == 1: the last bit of the word is on the line
//   empty_o      counter == 0
module i2s_tx_serializer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              load_msb_o,
    output logic              msb_o,
    output logic              next_msb_o,
    output logic              last_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  sh_amt;
    logic [DATA_W-1:0] aligned;

    // Left-align so the word MSB lands in the top bit; bits above len_i fall off the top.
    assign sh_amt  = LEN_W'(DATA_W) - len_i;
    assign aligned = data_i << sh_amt;

    assign load_msb_o = aligned[DATA_W-1];
    assign msb_o      = shreg_q[DATA_W-1];
    assign next_msb_o = shreg_q[DATA_W-2];
    assign last_o     = (cnt_q == LEN_W'(1));
    assign empty_o    = (cnt_q == '0);

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shreg_d = aligned;
            cnt_d   = len_i;
        end else if (shift_i && !empty_o) begin
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: serializes parallel audio words (5..DATA_W bits, MSB first) onto
// SD/WS with a valid qualifier. Word boundaries are a WS toggle or out_valid falling;
// consecutive same-channel words get a one-cycle gap so a receiver can split them.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   upstream word available
//   in_ready_o   word accepted this cycle if in_valid_i (depends on state only)
//   in_data_i    word, right-aligned
//   in_len_i     word length in bits
//   in_ch_i      channel: 0 left, 1 right
//   out_valid_o  sd_o carries a valid bit
//   sd_o         serial data, MSB first
//   ws_o         word select, channel of the current bit
//   len_err_o    one-cycle pulse after a word with illegal length is dropped
//   busy_o       word being shifted or gap pending
module i2s_tx import i2s_pkg::*; #(
    parameter int unsigned DATA_W  = I2S_DATA_W,
    parameter int unsigned MIN_LEN = I2S_MIN_LEN,
    parameter int unsigned LEN_W   = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [LEN_W-1:0]  in_len_i,
    input  logic              in_ch_i,
    output logic              out_valid_o,
    output logic              sd_o,
    output logic              ws_o,
    output logic              len_err_o,
    output logic              busy_o
);

    localparam logic [LEN_W-1:0] MinLen = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(DATA_W);

    tx_state_e state_q, state_d;
    logic      out_valid_q, out_valid_d;
    logic      sd_q, sd_d;
    logic      ws_q, ws_d;
    logic      len_err_q, len_err_d;

    logic accept, len_ok, legal_accept, end_of_word;
    logic ser_load, ser_shift;
    logic ser_load_msb, ser_msb, ser_next_msb, ser_last, ser_empty;

    i2s_tx_serializer #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_serializer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (ser_load),
        .shift_i    (ser_shift),
        .data_i     (in_data_i),
        .len_i      (in_len_i),
        .load_msb_o (ser_load_msb),
        .msb_o      (ser_msb),
        .next_msb_o (ser_next_msb),
        .last_o     (ser_last),
        .empty_o    (ser_empty)
    );

    always_comb begin
        in_ready_o = 1'b0;
        unique case (state_q)
            IDLE:    in_ready_o = 1'b1;
            SHIFT:   in_ready_o = ser_last;
            GAP:     in_ready_o = 1'b0;
            default: in_ready_o = 1'b0;
        endcase
    end

    assign accept       = in_valid_i && in_ready_o;
    assign len_ok       = (in_len_i >= MinLen) && (in_len_i <= MaxLen);
    assign legal_accept = accept && len_ok;
    // An empty counter in SHIFT cannot occur in normal flow; treat it as end of word.
    assign end_of_word  = ser_last || ser_empty;

    // ws_q doubles as the channel of the word in flight (and the last channel sent).
    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        sd_d        = 1'b0;
        ws_d        = ws_q;
        len_err_d   = accept && !len_ok;
        ser_load    = 1'b0;
        ser_shift   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (legal_accept) begin
                    ser_load    = 1'b1;
                    state_d     = SHIFT;
                    out_valid_d = 1'b1;
                    sd_d        = ser_load_msb;
                    ws_d        = in_ch_i;
                end
            end
            SHIFT: begin
                if (!end_of_word) begin
                    ser_shift   = 1'b1;
                    out_valid_d = 1'b1;
                    sd_d        = ser_next_msb;
                end else if (legal_accept && (in_ch_i != ws_q)) begin
                    // Channel change: the WS toggle delimits the words, no gap needed.
                    ser_load    = 1'b1;
                    out_valid_d = 1'b1;
                    sd_d        = ser_load_msb;
                    ws_d        = in_ch_i;
                end else if (legal_accept) begin
                    // Same channel: park the word for one idle cycle so valid drops.
                    ser_load = 1'b1;
                    state_d  = GAP;
                end else begin
                    ser_shift = 1'b1;
                    state_d   = IDLE;
                end
            end
            GAP: begin
                state_d     = SHIFT;
                out_valid_d = 1'b1;
                sd_d        = ser_msb;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            sd_q        <= 1'b0;
            ws_q        <= CH_LEFT;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            sd_q        <= sd_d;
            ws_q        <= ws_d;
            len_err_q   <= len_err_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign sd_o        = sd_q;
    assign ws_o        = ws_q;
    assign len_err_o   = len_err_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: directed cases plus a random word stream checked by
// recovering words from the serial output the way a receiver would.
module tb_i2s_tx;

    localparam int unsigned DW = 32;
    localparam int unsigned LW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [LW-1:0] in_len = '0;
    logic          in_ch = 1'b0;
    logic          out_valid, sd, ws, len_err, busy;

    i2s_tx #(
        .DATA_W  (DW),
        .MIN_LEN (5),
        .LEN_W   (LW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_len_i    (in_len),
        .in_ch_i     (in_ch),
        .out_valid_o (out_valid),
        .sd_o        (sd),
        .ws_o        (ws),
        .len_err_o   (len_err),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic [5:0] len; logic ch; int gap; } stim_t;
    typedef struct { logic ov; logic sd; logic ws; logic rdy; logic lerr; logic busy; } samp_t;
    typedef struct { logic [31:0] data; int len; logic ch; } word_t;

    stim_t stim_q[$];
    samp_t log_q[$];
    word_t exp_q[$];
    word_t got_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present the head of the stimulus queue (after its idle gap) or idle.
    task automatic drive();
        if (stim_q.size() == 0) begin
            in_valid = 1'b0;
        end else if (stim_q[0].gap > 0) begin
            in_valid = 1'b0;
            stim_q[0].gap = stim_q[0].gap - 1;
        end else begin
            in_valid = 1'b1;
            in_data  = stim_q[0].data;
            in_len   = stim_q[0].len;
            in_ch    = stim_q[0].ch;
        end
    endtask

    // One clock: accept decided from values stable before the edge, outputs logged at negedge.
    task automatic step();
        logic acc;
        acc = in_valid && in_ready;
        @(posedge clk);
        @(negedge clk);
        if (acc && stim_q.size() != 0) void'(stim_q.pop_front());
        log_q.push_back(samp_t'{out_valid, sd, ws, in_ready, len_err, busy});
        drive();
    endtask

    task automatic do_reset();
        stim_q.delete();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        log_q.delete();
    endtask

    task automatic chk_word(input int base, input logic [31:0] val, input int len,
                            input logic ch, input string tag);
        for (int i = 0; i < len; i++) begin
            chk($sformatf("%s_ov[%0d]", tag, i), 32'(log_q[base+i].ov), 32'd1);
            chk($sformatf("%s_sd[%0d]", tag, i), 32'(log_q[base+i].sd), 32'(val[len-1-i]));
            chk($sformatf("%s_ws[%0d]", tag, i), 32'(log_q[base+i].ws), 32'(ch));
        end
    endtask

    // Receiver view: a word is a run of valid bits on one WS level.
    task automatic parse();
        logic        in_word;
        logic [31:0] acc;
        int          alen;
        logic        ach;
        got_q.delete();
        in_word = 1'b0;
        acc = '0;
        alen = 0;
        ach = 1'b0;
        foreach (log_q[k]) begin
            if (in_word && (!log_q[k].ov || log_q[k].ws != ach)) begin
                got_q.push_back(word_t'{acc, alen, ach});
                in_word = 1'b0;
            end
            if (log_q[k].ov) begin
                if (!in_word) begin
                    in_word = 1'b1;
                    acc = '0;
                    alen = 0;
                    ach = log_q[k].ws;
                end
                acc = {acc[30:0], log_q[k].sd};
                alen++;
            end
        end
        if (in_word) got_q.push_back(word_t'{acc, alen, ach});
    endtask

    initial begin
        int          n_illegal;
        int          n_lerr;
        int          n_bad_busy;
        int          guard;
        logic [5:0]  len;
        logic [31:0] data;
        logic        ch;
        logic [63:0] m;

        // Reset values
        do_reset();
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_sd", 32'(sd), 32'd0);
        chk("rst_ws", 32'(ws), 32'd0);
        chk("rst_lerr", 32'(len_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);

        // Reset in the middle of a right-channel word
        stim_q.push_back(stim_t'{32'h0000BEEF, 6'd16, 1'b1, 0});
        drive();
        repeat (5) step();
        chk("midrst_pre_ov", 32'(log_q[4].ov), 32'd1);
        chk("midrst_pre_ws", 32'(log_q[4].ws), 32'd1);
        rst = 1'b1;
        stim_q.delete();
        in_valid = 1'b0;
        step();
        chk("midrst_ov", 32'(out_valid), 32'd0);
        chk("midrst_sd", 32'(sd), 32'd0);
        chk("midrst_ws", 32'(ws), 32'd0);
        chk("midrst_rdy", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Back-to-back alternating channels: no gap
        do_reset();
        stim_q.push_back(stim_t'{32'h16, 6'd5, 1'b0, 0});
        stim_q.push_back(stim_t'{32'hA5, 6'd8, 1'b1, 0});
        drive();
        repeat (16) step();
        chk_word(0, 32'h16, 5, 1'b0, "b2b0");
        chk_word(5, 32'hA5, 8, 1'b1, "b2b1");
        chk("b2b_end_ov", 32'(log_q[13].ov), 32'd0);
        parse();
        chk("b2b_nwords", got_q.size(), 32'd2);
        chk("b2b_left", got_q[0].data, 32'h16);
        chk("b2b_left_ch", 32'(got_q[0].ch), 32'd0);
        chk("b2b_right", got_q[1].data, 32'hA5);
        chk("b2b_right_ch", 32'(got_q[1].ch), 32'd1);

        // Same channel twice: one gap cycle
        do_reset();
        stim_q.push_back(stim_t'{32'h3F, 6'd6, 1'b0, 0});
        stim_q.push_back(stim_t'{32'h01, 6'd6, 1'b0, 0});
        drive();
        repeat (15) step();
        chk_word(0, 32'h3F, 6, 1'b0, "same0");
        chk("gap_ov", 32'(log_q[6].ov), 32'd0);
        chk("gap_sd", 32'(log_q[6].sd), 32'd0);
        chk("gap_ws", 32'(log_q[6].ws), 32'd0);
        chk("gap_rdy", 32'(log_q[6].rdy), 32'd0);
        chk("gap_busy", 32'(log_q[6].busy), 32'd1);
        chk_word(7, 32'h01, 6, 1'b0, "same1");
        chk("same_end_ov", 32'(log_q[13].ov), 32'd0);

        // Illegal lengths 4 and 33 are consumed and dropped
        do_reset();
        stim_q.push_back(stim_t'{32'h0000000F, 6'd4, 1'b1, 0});
        drive();
        chk("ill4_rdy", 32'(in_ready), 32'd1);
        step();
        step();
        chk("ill4_lerr", 32'(log_q[0].lerr), 32'd1);
        chk("ill4_ov", 32'(log_q[0].ov), 32'd0);
        chk("ill4_busy", 32'(log_q[0].busy), 32'd0);
        chk("ill4_lerr_end", 32'(log_q[1].lerr), 32'd0);
        chk("ill4_ov2", 32'(log_q[1].ov), 32'd0);
        chk("ill4_rdy2", 32'(log_q[1].rdy), 32'd1);
        log_q.delete();
        stim_q.push_back(stim_t'{32'hFFFFFFFF, 6'd33, 1'b0, 0});
        drive();
        chk("ill33_rdy", 32'(in_ready), 32'd1);
        step();
        step();
        chk("ill33_lerr", 32'(log_q[0].lerr), 32'd1);
        chk("ill33_ov", 32'(log_q[0].ov), 32'd0);
        chk("ill33_busy", 32'(log_q[0].busy), 32'd0);
        chk("ill33_lerr_end", 32'(log_q[1].lerr), 32'd0);
        chk("ill33_ov2", 32'(log_q[1].ov), 32'd0);

        // Full-width word
        do_reset();
        stim_q.push_back(stim_t'{32'h80000001, 6'd32, 1'b1, 0});
        drive();
        repeat (34) step();
        chk_word(0, 32'h80000001, 32, 1'b1, "full");
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("full_rdy[%0d]", i), 32'(log_q[i].rdy), (i == 31) ? 32'd1 : 32'd0);
        end
        chk("full_end_ov", 32'(log_q[32].ov), 32'd0);

        // Bits above in_len are ignored
        do_reset();
        stim_q.push_back(stim_t'{32'hFFFFFFE9, 6'd5, 1'b0, 0});
        drive();
        repeat (7) step();
        chk_word(0, 32'h09, 5, 1'b0, "mask");
        chk("mask_end_ov", 32'(log_q[5].ov), 32'd0);

        // Random stream against a receiver-level model
        do_reset();
        exp_q.delete();
        n_illegal = 0;
        for (int w = 0; w < 40; w++) begin
            len  = 6'($urandom_range(2, 36));
            data = $urandom();
            ch   = 1'($urandom_range(0, 1));
            stim_q.push_back(stim_t'{data, len, ch,
                                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0});
            if (len >= 6'd5 && len <= 6'd32) begin
                m = (64'd1 << len) - 64'd1;
                exp_q.push_back(word_t'{data & m[31:0], int'(len), ch});
            end else begin
                n_illegal++;
            end
        end
        drive();
        guard = 0;
        while (stim_q.size() != 0 && guard < 4000) begin
            step();
            guard++;
        end
        chk("rand_drained", stim_q.size(), 32'd0);
        repeat (40) step();
        parse();
        chk("rand_nwords", got_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            chk($sformatf("rand_data[%0d]", i), got_q[i].data, exp_q[i].data);
            chk($sformatf("rand_len[%0d]", i), got_q[i].len, exp_q[i].len);
            chk($sformatf("rand_ch[%0d]", i), 32'(got_q[i].ch), 32'(exp_q[i].ch));
        end
        n_lerr = 0;
        n_bad_busy = 0;
        foreach (log_q[k]) begin
            if (log_q[k].lerr) n_lerr++;
            if (log_q[k].ov && !log_q[k].busy) n_bad_busy++;
            if (!log_q[k].ov && log_q[k].busy && log_q[k].rdy) n_bad_busy++;
        end
        chk("rand_lerr_count", n_lerr, n_illegal);
        chk("rand_busy_consistency", n_bad_busy, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
Serializes parallel audio words into the same single-bit SD/WS/valid stream that the team's I2S receiver consumes.
- Words are 5..32 bits, MSB first, with a per-word channel tag.
- WS level selects the channel: 0 = left, 1 = right.
- Word boundaries are marked by a WS toggle or by out_valid falling, so a receiver recovers each word unchanged.
- Sits between the audio sample source (valid/ready handshake) and the serial link or loopback bench.

Parameters:
DATA_W, 32, maximum word width and width of in_data
MIN_LEN, 5, shortest legal word length; shorter words are rejected
LEN_W, 6, width of in_len (must encode DATA_W)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset; synchronous, active-high
in_valid  input  1  upstream word available
in_ready  output  1  block accepts a word this cycle
in_data  input  DATA_W  word, right-aligned (LSB at bit 0)
in_len  input  LEN_W  word length in bits
in_ch  input  1  channel: 0 left, 1 right
out_valid  output  1  SD carries a valid bit (receiver in_valid)
SD  output  1  serial data, MSB first
WS  output  1  word select (channel of current bit)
len_err  output  1  one-cycle pulse when a word with illegal length is dropped
busy  output  1  word being shifted or gap pending

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: out_valid=0, SD=0, WS=0, len_err=0, busy=0, state=IDLE, shift reg/counter=0, last_ch=0.
  - Reset mid-word discards the word; the next cycle shows out_valid=0.
- Registers: out_valid, SD, WS and len_err are registered.
- in_ready is combinational from state only, never from in_valid:
  - 1 in IDLE;
  - 1 in SHIFT when bit counter==1 (last bit of current word);
  - 0 in GAP.
- Accept condition: in_valid && in_ready at a rising edge. Upstream holds in_data, in_len and in_ch stable while in_valid && !in_ready.
- Length check at accept:
  - Legal: MIN_LEN <= in_len <= DATA_W.
  - Otherwise the word is consumed but not sent, len_err pulses next cycle, and the FSM behaves as if no word was offered.
- Load: shift reg = in_data << (DATA_W - in_len), left-aligning the MSB; counter = in_len.
  - Bits of in_data above in_len are ignored.
- State IDLE:
  - On legal accept -> SHIFT; SD/WS/out_valid update at that same edge, so the MSB is visible the cycle after accept (latency 1).
  - Outputs in IDLE: out_valid=0, SD=0, WS holds its last value.
- State SHIFT, each cycle:
  - SD = shreg[DATA_W-1], WS = current channel, out_valid=1.
  - Shift left, counter-1.
  - A word of length L produces exactly L consecutive out_valid=1 cycles.
- End of word (counter==1):
  - No legal accept -> IDLE; out_valid falls next cycle.
  - Legal accept, in_ch != current channel -> reload, stay in SHIFT. The new MSB and the toggled WS appear on the very next cycle (no gap).
  - Legal accept, in_ch == current channel -> GAP.
- State GAP:
  - One cycle: out_valid=0, SD=0, WS holds.
  - Then -> SHIFT with the stored word.
  - Required because the receiver delimits same-channel words only via out_valid falling.
- WS alignment: WS changes in the same cycle as the first bit of the new word; there is no 1-bit I2S delay.
- busy=1 in SHIFT and GAP.

Decomposition:
- Package i2s_pkg:
  - state enum tx_state_e {IDLE, SHIFT, GAP};
  - constants I2S_DATA_W=32, I2S_MIN_LEN=5;
  - channel constants CH_LEFT=0, CH_RIGHT=1.
- Sub-module i2s_tx_serializer:
  - shift register plus down-counter, with load/shift/empty interface;
  - the FSM and handshake stay in i2s_tx.

Test Plan:
- Reset: assert rst with a word mid-shift -> next cycle out_valid=0, SD=0, WS=0, in_ready=1, busy=0.
- Back-to-back alternating channels: left len5 data 0x16, immediately followed by right len8 data 0xA5.
  - Required out_valid=1 for 13 consecutive cycles.
  - SD = 1,0,1,1,0 with WS=0, then 1,0,1,0,0,1,0,1 with WS=1, then out_valid=0.
  - Loopback receiver yields out_left=0x16, then out_right=0xA5.
- Same channel twice: two left len6 words 0x3F, 0x01.
  - Required: 6 valid cycles, 1 gap cycle (out_valid=0, WS=0), 6 valid cycles (SD=0,0,0,0,0,1).
  - in_ready=0 during the gap.
- Illegal length: in_len=4 offered in IDLE -> accepted (in_ready=1), len_err=1 for one cycle, out_valid stays 0, FSM stays IDLE.
  - in_len=33 gives the same result.
- Full width: right len32 data 0x80000001 -> 32 valid cycles, SD=1, then 30 zeros, then 1, with WS=1 throughout; in_ready=1 only in the 32nd cycle.
- Upper-bit masking: len5 data 0xFFFFFFE9 -> SD=0,1,0,0,1 (only bits 4:0 sent).
